// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// imem handshake and loads the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        ID_Flush,
  input  logic        stall,
  output logic [31:0] pc,
  if_stage_if.master  imem,
  output logic        ID_valid,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_instr
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;

  logic        w_req_valid;
  logic        w_hs;
  logic        w_resp;
  logic        w_xfer;
  logic        w_capture;
  logic [31:0] w_xfer_instr;

  assign w_resp = imem.imem_resp_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a flush always wins over stall and over response delivery
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_hs) begin
          w_state_nxt = ID_Flush ? S_DRAIN : S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (w_resp) begin
          w_state_nxt = (stall && !ID_Flush) ? S_HOLD : S_REQ;
        end else begin
          w_state_nxt = ID_Flush ? S_DRAIN : S_WAIT;
        end
      end
      S_HOLD: begin
        if (ID_Flush || !stall) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (w_resp) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Output decode: request strobe and instruction-transfer controls
  always_comb begin
    w_req_valid  = 1'b0;
    w_xfer       = 1'b0;
    w_capture    = 1'b0;
    w_xfer_instr = imem.imem_resp_data;
    case (r_state)
      S_REQ: begin
        w_req_valid = 1'b1;
      end
      S_WAIT: begin
        w_xfer    = w_resp & ~ID_Flush & ~stall;
        w_capture = w_resp & ~ID_Flush & stall;
      end
      S_HOLD: begin
        w_xfer       = ~ID_Flush & ~stall;
        w_xfer_instr = r_hold;
      end
      S_DRAIN: begin
        w_req_valid = 1'b0;
      end
      default: begin
        w_req_valid = 1'b0;
      end
    endcase
    w_hs = w_req_valid & imem.imem_req_ready;
  end

  // PC, hold buffer and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_hold     <= 32'h0000_0000;
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'h0000_0000;
      r_id_instr <= NOP_INSTR;
    end else begin
      if (ID_Flush || w_xfer) begin
        r_pc <= next_pc;
      end
      if (w_capture) begin
        r_hold <= imem.imem_resp_data;
      end
      if (ID_Flush) begin
        r_id_valid <= 1'b0;
        r_id_pc    <= 32'h0000_0000;
        r_id_instr <= NOP_INSTR;
      end else if (stall) begin
        r_id_valid <= r_id_valid;
      end else if (w_xfer) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= r_pc;
        r_id_instr <= w_xfer_instr;
      end else begin
        r_id_valid <= 1'b0;
        r_id_pc    <= 32'h0000_0000;
        r_id_instr <= NOP_INSTR;
      end
    end
  end

  assign pc                  = r_pc;
  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_addr      = r_pc;
  assign ID_valid            = r_id_valid;
  assign ID_pc               = r_id_pc;
  assign ID_instr            = r_id_instr;

endmodule
